// File: rtl/pe_link_arbiter.sv
// pe_link_arbiter
//   Packet-level round-robin arbiter and credit controller that lets NUM_REQ
//   processing elements share a single router injection link. A grant is
//   held from HEAD to TAIL; SINGLE flits are one-flit packets. Downstream
//   buffer space is tracked by a credit counter: one credit is spent per flit
//   sent and one is returned per high cycle of ci.
//
//   Optional build macro: PE_LINK_CREDIT_ERR_EN adds a sticky credit_err
//   output that flags a credit return arriving while the counter is full.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   req_data    NUM_REQ flits, requester i at [i*FLIT_W +: FLIT_W]
//   req_valid   requester i presents a flit
//   req_ready   flit from requester i accepted this cycle (combinational)
//   out_data    flit on the router link (registered)
//   out_valid   out_data valid for this cycle (registered)
//   ci          credit return, one credit per high cycle
//   grant_id    index of the current or last owner (registered)
//   credit_cnt  credits currently available (registered)
//   credit_err  sticky credit overflow flag (only with PE_LINK_CREDIT_ERR_EN)
module pe_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 20,
  parameter int CREDITS = 7,
  parameter int CNT_W   = 3,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*FLIT_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      ci,
  output logic [ID_W-1:0]           grant_id,
  output logic [CNT_W-1:0]          credit_cnt
`ifdef PE_LINK_CREDIT_ERR_EN
  ,
  output logic                      credit_err
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  state_t              state;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  elig;
  logic [ID_W-1:0]     winner;
  logic                found;
  logic [ID_W-1:0]     sel;
  logic [FLIT_W-1:0]   sel_flit;
  logic [1:0]          sel_type;
  logic                send;

  // Round-robin successor, correct for non-power-of-two NUM_REQ.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    if (i == ID_W'(NUM_REQ - 1)) next_idx = '0;
    else                         next_idx = i + ID_W'(1);
  endfunction

  // Credit counter update: spend on send, return on ci, saturate at CREDITS.
  function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] cnt,
                                                    input logic snd,
                                                    input logic c);
    if (snd && !c)                                 credit_next = cnt - CNT_W'(1);
    else if (!snd && c && cnt != CNT_W'(CREDITS))  credit_next = cnt + CNT_W'(1);
    else                                           credit_next = cnt;
  endfunction

  // HEAD (10) and SINGLE (11) share a set MSB, so that bit alone marks a
  // flit that may open a new grant.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
    assign elig[g] = req_valid[g] & req_data[g*FLIT_W + FLIT_W - 1];
  end

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Ready is decoded from the registered credit count, so a credit returned
  // at zero only opens the link on the following cycle.
  always_comb begin
    req_ready = '0;
    if (!rst && credit_cnt != '0) begin
      if (state == LOCKED) req_ready[owner]  = req_valid[owner];
      else if (found)      req_ready[winner] = 1'b1;
    end
  end

  assign sel      = (state == LOCKED) ? owner : winner;
  assign send     = |(req_valid & req_ready);
  assign sel_flit = req_data[int'(sel)*FLIT_W +: FLIT_W];
  assign sel_type = sel_flit[FLIT_W-1 -: 2];

  // Accept -> link register stage (one cycle latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      grant_id   <= '0;
      credit_cnt <= CNT_W'(CREDITS);
`ifdef PE_LINK_CREDIT_ERR_EN
      credit_err <= 1'b0;
`endif
    end else begin
      out_valid  <= send;
      credit_cnt <= credit_next(credit_cnt, send, ci);
      if (send) begin
        out_data <= sel_flit;
        grant_id <= sel;
      end
`ifdef PE_LINK_CREDIT_ERR_EN
      if (ci && !send && credit_cnt == CNT_W'(CREDITS)) credit_err <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (send) begin
            if (sel_type == T_HEAD) begin
              state <= LOCKED;
              owner <= sel;
            end else if (sel_type == T_SINGLE) begin
              rr_ptr <= next_idx(sel);
            end
          end
        end
        LOCKED: begin
          if (send && sel_type == T_TAIL) begin
            state  <= IDLE;
            rr_ptr <= next_idx(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
